sevenseg_scan_decoder: RTL and testbench

Receive-side counterpart of the team's hex-to-seven-segment encoder. It observes a multiplexed, active-low seven-segment display bus (one shared segment bus plus active-low digit enables) and recovers the displayed hex value. Each digit pattern is debounced and decoded back to a nibble. A full frame is assembled and presented on a valid/ready output. Used for display loopback self-test and for verification capture on the calculator board.

---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/sevenseg_scan_decoder_debounce.sv | 57 +++++
 rtl/sevenseg_scan_decoder.sv | 91 +++++++++
 tb/tb_sevenseg_scan_decoder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared seven-segment pattern types, hex pattern table and decoder
package sevenseg_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {SCAN, HOLD} state_t;
  localparam seg_t SEG_0 = 7'h01;
  localparam seg_t SEG_1 = 7'h4F;
  localparam seg_t SEG_2 = 7'h12;
  localparam seg_t SEG_3 = 7'h06;
  localparam seg_t SEG_4 = 7'h4C;
  localparam seg_t SEG_5 = 7'h24;
  localparam seg_t SEG_6 = 7'h20;
  localparam seg_t SEG_7 = 7'h0F;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h0C;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h60;
  localparam seg_t SEG_C = 7'h31;
  localparam seg_t SEG_D = 7'h42;
  localparam seg_t SEG_E = 7'h30;
  localparam seg_t SEG_F = 7'h38;
  localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  // returns {valid, nibble}; unknown patterns give {0, 0}
  function automatic logic [4:0] seg_decode(input seg_t p);
    logic [4:0] r;
    r = 5'h00;
    for (int i = 0; i < 16; i++) if (p == SEG_TABLE[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/sevenseg_scan_decoder_debounce.sv
// seg_debounce: synchronizes the display bus, classifies each sample and commits stable digits
module seg_debounce
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  seg_t                  seg_n_i,
  input  logic [NUM_DIGITS-1:0] an_n_i,
  output logic                  commit_o,
  output logic [IW-1:0]         idx_o,
  output seg_t                  pat_o,
  output logic                  multi_o
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  seg_t seg_s1_q, seg_s2_q, seg_p_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_p_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic blank, single, same;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      seg_p_q  <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      an_p_q   <= '1;
      cnt_q    <= '0;
    end else begin
      seg_s1_q <= seg_n_i;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      an_s1_q  <= an_n_i;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
      cnt_q    <= cnt_d;
    end
  end
  // comparing the whole enable vector also rejects runs that started from blank or multi
  always_comb begin
    blank    = &an_s2_q;
    single   = $onehot(~an_s2_q);
    same     = (an_s2_q == an_p_q) && (seg_s2_q == seg_p_q);
    cnt_d    = (!en_i || !single) ? '0 :
               !same ? CW'(1) :
               (cnt_q == CW'(STABLE_CNT)) ? cnt_q : cnt_q + CW'(1);
    commit_o = en_i && single && (cnt_d == CW'(STABLE_CNT)) && (cnt_q != CW'(STABLE_CNT) || !same);
    multi_o  = en_i && !blank && !single;
    pat_o    = seg_s2_q;
    idx_o    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (!an_s2_q[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder: recovers hex frames from a multiplexed active-low seven-segment bus
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int STABLE_CNT  = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_timeout,
  output logic                    out_bus_err
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t state_q;
  logic [4*NUM_DIGITS-1:0] nib_q, value_q;
  logic [NUM_DIGITS-1:0] mask_q, derr_q;
  logic [TW-1:0] tcnt_q;
  logic err_q, valid_q, timeout_q, bus_err_q;
  logic commit, multi;
  logic [IW-1:0] idx;
  seg_t pat;
  logic [4:0] dec;
  seg_debounce #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CNT(STABLE_CNT)) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q == SCAN),
    .seg_n_i  (seg_n),
    .an_n_i   (an_n),
    .commit_o (commit),
    .idx_o    (idx),
    .pat_o    (pat),
    .multi_o  (multi)
  );
  assign dec         = seg_decode(pat);
  assign out_value   = value_q;
  assign out_err     = err_q;
  assign out_valid   = valid_q;
  assign out_timeout = timeout_q;
  assign out_bus_err = bus_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      nib_q     <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      derr_q    <= '0;
      tcnt_q    <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (multi) bus_err_q <= 1'b1;
      if (state_q == SCAN) begin
        if (commit) begin
          nib_q[4*idx +: 4] <= dec[3:0];
          derr_q[idx]       <= !dec[4];
          mask_q[idx]       <= 1'b1;
          tcnt_q            <= '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          mask_q    <= '0;
          derr_q    <= '0;
          timeout_q <= 1'b1;
          tcnt_q    <= '0;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
        if (&mask_q) begin
          state_q <= HOLD;
          value_q <= nib_q;
          err_q   <= |derr_q;
          valid_q <= 1'b1;
        end
      end else if (out_ready) begin
        state_q <= SCAN;
        valid_q <= 1'b0;
        mask_q  <= '0;
        derr_q  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder: directed checks of frame capture, glitches, errors, backpressure, timeout, reset
module tb_sevenseg_scan_decoder;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [6:0] seg_n = '1;
  logic [N-1:0] an_n = '1;
  logic [4*N-1:0] out_value;
  logic out_err, out_valid, out_timeout, out_bus_err;
  int n_chk = 0, n_fail = 0, vcycles = 0, v0 = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) vcycles++;

  sevenseg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CNT(3), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .out_value   (out_value),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_timeout (out_timeout),
    .out_bus_err (out_bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show(input int k, input logic [6:0] p, input int n);
    an_n = '1;
    an_n[k] = 1'b0;
    seg_n = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an_n = '1;
    seg_n = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
    show(3, p3, 5);
    show(2, p2, 5);
    show(1, p1, 5);
    show(0, p0, 5);
    idle(1);
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk(tag, 32'(seen), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(out_value), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_timeout", 32'(out_timeout), 0);
    chk("rst_bus_err", 32'(out_bus_err), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(4);
    // plain scan 7,2,3,8
    frame4(7'h0F, 7'h12, 7'h06, 7'h00);
    wait_valid("scan_valid");
    chk("scan_value", 32'(out_value), 32'h7238);
    chk("scan_err", 32'(out_err), 0);
    @(negedge clk);
    chk("scan_pulse", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("scan_bus_err", 32'(out_bus_err), 0);
    // glitch on the last digit: 1 shown briefly, then 5
    v0 = vcycles;
    show(3, 7'h08, 5);
    show(2, 7'h60, 5);
    show(1, 7'h31, 5);
    show(0, 7'h4F, 2);
    show(0, 7'h24, 4);
    idle(1);
    wait_valid("glitch_valid");
    chk("glitch_value", 32'(out_value), 32'hABC5);
    chk("glitch_err", 32'(out_err), 0);
    @(posedge clk);
    #1;
    chk("glitch_frames", 32'(vcycles - v0), 1);
    // undecodable digit 2, then two enables low
    frame4(7'h42, 7'h7F, 7'h30, 7'h38);
    wait_valid("inv_valid");
    chk("inv_value", 32'(out_value), 32'hD0EF);
    chk("inv_err", 32'(out_err), 1);
    @(posedge clk);
    #1;
    an_n = 4'b1100;
    seg_n = 7'h01;
    @(posedge clk);
    #1;
    idle(5);
    chk("multi_bus_err", 32'(out_bus_err), 1);
    // backpressure
    out_ready = 1'b0;
    frame4(7'h01, 7'h4F, 7'h12, 7'h06);
    wait_valid("bp_valid");
    chk("bp_value", 32'(out_value), 32'h0123);
    @(posedge clk);
    #1;
    show(3, 7'h24, 10);
    show(0, 7'h4C, 10);
    idle(5);
    chk("bp_hold_value", 32'(out_value), 32'h0123);
    chk("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_accept", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    v0 = vcycles;
    show(2, 7'h20, 5);
    show(1, 7'h0F, 5);
    show(0, 7'h00, 5);
    idle(3);
    chk("bp_partial", 32'(vcycles - v0), 0);
    show(3, 7'h24, 5);
    idle(1);
    wait_valid("bp_next_valid");
    chk("bp_next_value", 32'(out_value), 32'h5678);
    @(posedge clk);
    #1;
    // timeout discards digits 0 and 1
    idle(40);
    show(0, 7'h0C, 5);
    show(1, 7'h08, 5);
    idle(15);
    @(negedge clk);
    chk("to_early", 32'(out_timeout), 0);
    @(negedge clk);
    chk("to_pulse", 32'(out_timeout), 1);
    @(negedge clk);
    chk("to_width", 32'(out_timeout), 0);
    @(posedge clk);
    #1;
    v0 = vcycles;
    show(3, 7'h4C, 5);
    show(2, 7'h06, 5);
    idle(3);
    chk("to_partial", 32'(vcycles - v0), 0);
    show(1, 7'h12, 5);
    show(0, 7'h4F, 5);
    idle(1);
    wait_valid("to_valid");
    chk("to_value", 32'(out_value), 32'h4321);
    chk("to_err", 32'(out_err), 0);
    @(posedge clk);
    #1;
    // asynchronous reset while a frame is held
    out_ready = 1'b0;
    frame4(7'h0C, 7'h08, 7'h60, 7'h31);
    wait_valid("rh_valid");
    chk("rh_value", 32'(out_value), 32'h9ABC);
    chk("rh_bus_err_sticky", 32'(out_bus_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_value", 32'(out_value), 0);
    chk("ra_valid", 32'(out_valid), 0);
    chk("ra_err", 32'(out_err), 0);
    chk("ra_timeout", 32'(out_timeout), 0);
    chk("ra_bus_err", 32'(out_bus_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    v0 = vcycles;
    show(3, 7'h42, 5);
    show(2, 7'h30, 5);
    show(1, 7'h38, 5);
    idle(3);
    chk("rr_partial", 32'(vcycles - v0), 0);
    show(0, 7'h01, 5);
    idle(1);
    wait_valid("rr_valid");
    chk("rr_value", 32'(out_value), 32'hDEF0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
